// File: rtl/tcb_pkg.sv
// tcb_pkg: helpers shared by the TCB delay adapter and its users.
// The response {rdt, sts} struct is declared inside tcb_lib_delay, because its width follows DBW.
package tcb_pkg;

   function automatic bit tcb_dly_check(input int unsigned man, input int unsigned sub);
      return sub >= man;
   endfunction

   function automatic int unsigned tcb_cnt_w(input int unsigned dly);
      return (dly > 0) ? $clog2(dly + 1) : 1;
   endfunction

endpackage

// File: rtl/tcb_lib_delay_line.sv
// tcb_lib_delay_line: {vld, data} shift register; each data stage loads only when its incoming vld is set.
module tcb_lib_delay_line #(
   parameter  int unsigned DEPTH = 1,
   parameter  int unsigned DW    = 0,
   localparam int unsigned WP    = (DW > 0) ? DW : 1
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          src_vld,
   input  logic [WP-1:0] src_dat,
   output logic          dst_vld,
   output logic [WP-1:0] dst_dat
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign dst_vld    = src_vld;
      assign dst_dat    = src_dat;
   end else begin : g_line
      logic [DEPTH-1:0] v;
      logic [DEPTH-1:0] pv;
      logic [WP-1:0]    d  [DEPTH];
      logic [WP-1:0]    pd [DEPTH];
      assign pv = DEPTH'({v, src_vld});
      always_comb begin
         pd[0] = src_dat;
         for (int i = 1; i < DEPTH; i++) pd[i] = d[i-1];
      end
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
         end else begin
            v <= pv;
            for (int i = 0; i < DEPTH; i++) if (pv[i]) d[i] <= pd[i];
         end
      assign dst_vld = v[DEPTH-1];
      assign dst_dat = d[DEPTH-1];
   end

endmodule

// File: rtl/tcb_lib_delay.sv
// tcb_lib_delay: forwards TCB requests untouched and re-times responses from a DLY_MAN
// subordinate so the upstream manager sees them DLY_SUB cycles after the handshake.
module tcb_lib_delay
   import tcb_pkg::*;
#(
   parameter  int unsigned ABW     = 32,
   parameter  int unsigned DBW     = 32,
   parameter  int unsigned BEW     = DBW/8,
   parameter  int unsigned DLY_MAN = 0,
   parameter  int unsigned DLY_SUB = 1,
   parameter  int unsigned RSP_HLD = 1,
   localparam int unsigned CW      = tcb_cnt_w(DLY_SUB)
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sub_vld,
   output logic           sub_rdy,
   input  logic           sub_wen,
   input  logic [ABW-1:0] sub_adr,
   input  logic [BEW-1:0] sub_ben,
   input  logic [DBW-1:0] sub_wdt,
   output logic [DBW-1:0] sub_rdt,
   output logic           sub_sts,
   output logic           man_vld,
   input  logic           man_rdy,
   output logic           man_wen,
   output logic [ABW-1:0] man_adr,
   output logic [BEW-1:0] man_ben,
   output logic [DBW-1:0] man_wdt,
   input  logic [DBW-1:0] man_rdt,
   input  logic           man_sts,
   output logic           rsp_vld,
   output logic [CW-1:0]  cnt
);

   localparam int unsigned D = tcb_dly_check(DLY_MAN, DLY_SUB) ? DLY_SUB - DLY_MAN : 0;

   if (!tcb_dly_check(DLY_MAN, DLY_SUB)) begin : g_err
      $error("tcb_lib_delay: DLY_SUB must not be smaller than DLY_MAN");
   end

   typedef struct packed {
      logic [DBW-1:0] rdt;
      logic           sts;
   } rsp_t;

   logic trn, man_rsp, unused_vdat;
   rsp_t lin, hld;

   assign trn     = sub_vld & man_rdy;
   assign sub_rdy = man_rdy;
   assign man_vld = sub_vld;
   assign man_wen = sub_wen;
   assign man_adr = sub_adr;
   assign man_ben = sub_ben;
   assign man_wdt = sub_wdt;

   tcb_lib_delay_line #(.DEPTH(DLY_MAN), .DW(0)) u_vld (
      .clk(clk), .rst_n(rst_n),
      .src_vld(trn),     .src_dat(1'b0),
      .dst_vld(man_rsp), .dst_dat(unused_vdat)
   );

   tcb_lib_delay_line #(.DEPTH(D), .DW(DBW+1)) u_dat (
      .clk(clk), .rst_n(rst_n),
      .src_vld(man_rsp), .src_dat({man_rdt, man_sts}),
      .dst_vld(rsp_vld), .dst_dat(lin)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         hld <= '0;
         cnt <= '0;
      end else begin
         if (rsp_vld) hld <= lin;
         if (trn != rsp_vld) cnt <= trn ? cnt + CW'(1) : cnt - CW'(1);
      end

   assign {sub_rdt, sub_sts} = rsp_vld ? lin : ((RSP_HLD != 0) ? hld : '0);

endmodule

// File: tb/tb_tcb_lib_delay.sv
// tb_tcb_lib_delay: four delay configurations driven by one stimulus stream, checked by a response scoreboard.
module tb_tcb_lib_delay;
   import tcb_pkg::*;

   localparam int ND = 4;
   localparam int MANS [ND] = '{1, 0, 1, 1};
   localparam int SUBS [ND] = '{1, 3, 2, 2};
   localparam int HLDS [ND] = '{1, 1, 0, 1};

   typedef struct {
      int          k;
      int          due;
      logic [31:0] rdt;
      logic        sts;
   } exp_t;

   exp_t q[$];
   logic clk = 0, rst_n = 0;
   logic vld = 0, wen = 0, rdy = 1, rsts = 0, d1_sts = 0;
   logic [31:0] adr = 0, wdt = 0, rrdt = 0, d1_rdt = 0;
   logic [3:0]  ben = 0;
   logic [31:0] s_rdt [ND], m_adr [ND], m_wdt [ND], m_rdt [ND];
   logic        s_rdy [ND], s_sts [ND], rv [ND], m_vld [ND], m_wen [ND], m_sts [ND];
   logic [3:0]  m_ben [ND], cnt_a [ND];
   logic [31:0] last_rdt [ND];
   logic        last_sts [ND];
   int checks = 0, failures = 0, cyc = 0;
   int idx, outst;

   always #5 clk = ~clk;

   // downstream subordinate with one cycle of response delay
   always @(posedge clk) begin
      cyc++;
      if (vld & rdy) begin
         d1_rdt <= rrdt;
         d1_sts <= rsts;
      end
   end

   for (genvar k = 0; k < ND; k++) begin : g_d
      localparam int CW = tcb_cnt_w(SUBS[k]);
      logic [CW-1:0] c;
      assign m_rdt[k] = (MANS[k] == 0) ? rrdt : d1_rdt;
      assign m_sts[k] = (MANS[k] == 0) ? rsts : d1_sts;
      assign cnt_a[k] = 4'(c);
      tcb_lib_delay #(.ABW(32), .DBW(32), .DLY_MAN(MANS[k]), .DLY_SUB(SUBS[k]), .RSP_HLD(HLDS[k])) u_dut (
         .clk(clk), .rst_n(rst_n),
         .sub_vld(vld), .sub_rdy(s_rdy[k]), .sub_wen(wen), .sub_adr(adr), .sub_ben(ben), .sub_wdt(wdt),
         .sub_rdt(s_rdt[k]), .sub_sts(s_sts[k]),
         .man_vld(m_vld[k]), .man_rdy(rdy), .man_wen(m_wen[k]), .man_adr(m_adr[k]), .man_ben(m_ben[k]),
         .man_wdt(m_wdt[k]), .man_rdt(m_rdt[k]), .man_sts(m_sts[k]),
         .rsp_vld(rv[k]), .cnt(c)
      );
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         for (int k = 0; k < ND; k++) begin
            last_rdt[k] = '0;
            last_sts[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < ND; k++) begin
            idx = -1;
            outst = 0;
            foreach (q[i]) if (q[i].k == k) begin
               outst++;
               if (q[i].due == cyc) idx = i;
            end
            checks++;
            if (cnt_a[k] !== 4'(outst)) begin
               failures++;
               $display("FAIL cnt dut%0d cyc%0d: got %0d want %0d", k, cyc, cnt_a[k], outst);
            end
            checks++;
            if ({s_rdy[k], m_vld[k], m_wen[k], m_adr[k], m_ben[k], m_wdt[k]} !== {rdy, vld, wen, adr, ben, wdt}) begin
               failures++;
               $display("FAIL req dut%0d cyc%0d: got %h want %h", k, cyc,
                        {s_rdy[k], m_vld[k], m_wen[k], m_adr[k], m_ben[k], m_wdt[k]}, {rdy, vld, wen, adr, ben, wdt});
            end
            checks++;
            if (idx >= 0) begin
               if ({rv[k], s_rdt[k], s_sts[k]} !== {1'b1, q[idx].rdt, q[idx].sts}) begin
                  failures++;
                  $display("FAIL rsp dut%0d cyc%0d: got vld=%b rdt=%h sts=%b want vld=1 rdt=%h sts=%b",
                           k, cyc, rv[k], s_rdt[k], s_sts[k], q[idx].rdt, q[idx].sts);
               end
               last_rdt[k] = q[idx].rdt;
               last_sts[k] = q[idx].sts;
               q.delete(idx);
            end else if ({rv[k], s_rdt[k], s_sts[k]} !==
                         {1'b0, (HLDS[k] != 0) ? last_rdt[k] : 32'h0, (HLDS[k] != 0) ? last_sts[k] : 1'b0}) begin
               failures++;
               $display("FAIL idle dut%0d cyc%0d: got vld=%b rdt=%h sts=%b want vld=0 hold=%0d last=%h",
                        k, cyc, rv[k], s_rdt[k], s_sts[k], HLDS[k], last_rdt[k]);
            end
         end
         if (vld & rdy) for (int k = 0; k < ND; k++) q.push_back('{k, cyc + SUBS[k], rrdt, rsts});
      end
   end

   task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic st);
      @(posedge clk);
      #1;
      vld  = v;
      wen  = w;
      adr  = a;
      wdt  = wd;
      rrdt = rd;
      rsts = st;
      ben  = 4'hF;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      for (int k = 0; k < ND; k++) begin
         checks++;
         if ({rv[k], s_rdt[k], s_sts[k], cnt_a[k]} !== 38'h0) begin
            failures++;
            $display("FAIL reset dut%0d: got vld=%b rdt=%h sts=%b cnt=%0d want all 0", k, rv[k], s_rdt[k], s_sts[k], cnt_a[k]);
         end
      end
      @(posedge clk);
      #3 rst_n = 1;
   endtask

   task automatic test_passthrough;
      drive(1, 1, 32'h01234567, 32'h76543210, 32'h0, 0);
      drive(1, 0, 32'h89ABCDEF, 32'h0, 32'hFEDCBA98, 0);
      drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
      @(negedge clk);
      checks++;
      if (rv[0] !== 1'b1 || s_rdt[0] !== 32'hFEDCBA98) begin
         failures++;
         $display("FAIL passthrough: got vld=%b rdt=%h want vld=1 rdt=fedcba98", rv[0], s_rdt[0]);
      end
      repeat (4) drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
   endtask

   task automatic test_back_to_back;
      logic [31:0] got [8];
      int n = 0, first = -1, t0 = 0;
      logic [3:0] peak = 0;
      for (int i = 0; i < 12; i++) begin
         if (i < 4) drive(1, 0, 32'h100 + 32'(i), 32'h0, 32'h11 * 32'(i + 1), 0);
         else drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
         @(negedge clk);
         if (i == 0) t0 = cyc;
         if (rv[1]) begin
            if (first < 0) first = cyc;
            if (n < 8) got[n] = s_rdt[1];
            n++;
         end
         if (cnt_a[1] > peak) peak = cnt_a[1];
      end
      checks++;
      if (n != 4 || first != t0 + 3) begin
         failures++;
         $display("FAIL b2b_count: got %0d responses from cyc %0d want 4 from cyc %0d", n, first, t0 + 3);
      end
      for (int i = 0; i < 4 && i < n; i++) begin
         checks++;
         if (got[i] !== 32'h11 * 32'(i + 1)) begin
            failures++;
            $display("FAIL b2b_data%0d: got %h want %h", i, got[i], 32'h11 * 32'(i + 1));
         end
      end
      checks++;
      if (peak !== 4'd3) begin
         failures++;
         $display("FAIL b2b_peak: got %0d want 3", peak);
      end
   endtask

   task automatic test_stalls;
      int hs = 0, rs = 0;
      for (int i = 0; i < 66; i++) begin
         if (i < 60) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
            rdy = ($urandom_range(0, 3) != 0);
         end else begin
            drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
            rdy = 1;
         end
         @(negedge clk);
         if (vld & rdy) hs++;
         if (rv[2]) rs++;
      end
      checks++;
      if (rs != hs) begin
         failures++;
         $display("FAIL stall_count: got %0d responses want %0d", rs, hs);
      end
   endtask

   task automatic test_hold;
      drive(1, 0, 32'h40, 32'h0, 32'hA5A5A5A5, 0);
      repeat (5) drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
      @(negedge clk);
      checks++;
      if (s_rdt[2] !== 32'h0 || s_rdt[3] !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL hold: got hld0=%h hld1=%h want 00000000 a5a5a5a5", s_rdt[2], s_rdt[3]);
      end
   endtask

   task automatic test_status;
      logic [2:0] pat = 0;
      for (int i = 0; i < 9; i++) begin
         if (i < 3) drive(1, 0, 32'h80 + 32'(i), 32'h0, 32'hC0 + 32'(i), i == 1);
         else drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
         @(negedge clk);
         if (rv[1]) pat = {pat[1:0], s_sts[1]};
      end
      checks++;
      if (pat !== 3'b010) begin
         failures++;
         $display("FAIL status: got %b want 010", pat);
      end
   endtask

   task automatic test_reset_mid;
      int n [ND];
      drive(1, 0, 32'h1, 32'h0, 32'h1, 0);
      drive(1, 0, 32'h2, 32'h0, 32'h2, 0);
      drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
      @(negedge clk);
      checks++;
      if (cnt_a[1] !== 4'd2) begin
         failures++;
         $display("FAIL mid_cnt: got %0d want 2", cnt_a[1]);
      end
      @(posedge clk);
      #3 rst_n = 0;
      #1;
      for (int k = 0; k < ND; k++) begin
         checks++;
         if ({rv[k], s_rdt[k], s_sts[k], cnt_a[k]} !== 38'h0) begin
            failures++;
            $display("FAIL mid_reset dut%0d: got vld=%b rdt=%h sts=%b cnt=%0d want all 0", k, rv[k], s_rdt[k], s_sts[k], cnt_a[k]);
         end
      end
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      for (int k = 0; k < ND; k++) n[k] = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) drive(1, 0, 32'h5, 32'h0, 32'h5A, 0);
         else drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
         @(negedge clk);
         for (int k = 0; k < ND; k++) if (rv[k]) n[k]++;
      end
      for (int k = 0; k < ND; k++) begin
         checks++;
         if (n[k] != 1) begin
            failures++;
            $display("FAIL post_reset dut%0d: got %0d responses want 1", k, n[k]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_passthrough;
      test_back_to_back;
      test_stalls;
      test_hold;
      test_status;
      test_reset_mid;
      repeat (2) drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending responses want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
